// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared terminator constants, capacity and FSM state encoding
package uart_cmd_pkg;
    localparam logic [7:0] UART_TERM0 = 8'hBE;
    localparam logic [7:0] UART_TERM1 = 8'hEF;
    localparam logic [7:0] BLE_TERM   = 8'h0D;
    localparam int         MAX_BYTES  = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_PEND_BE,
        ST_DONE,
        ST_ERROR
    } state_e;
endpackage

// File: rtl/cmd_timeout_counter.sv
// rtl/cmd_timeout_counter.sv - inter-byte idle counter, expires after TIMEOUT quiet cycles
module cmd_timeout_counter #(
    parameter int TIMEOUT = 1026
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry fires on the TIMEOUT-th quiet edge after the last accepted byte.
    always_comb begin
        expired_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT - 1));
        cnt_d     = cnt_q;
        if (!enable_i || clear_i) begin
            cnt_d = '0;
        end else if (!expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_command_accumulator.sv
// rtl/uart_command_accumulator.sv - gathers UART/BLE bytes into a 1024-bit command buffer
module uart_command_accumulator
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 1026
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    input_data,
    input  logic          accumulate,
    input  logic          ble_side,
    output logic [1023:0] output_data,
    output logic [7:0]    output_data_size,
    output logic          done,
    output logic          error
);
    state_e          state_q, state_d, st_ok;
    logic [1023:0]   data_q, data_d;
    logic [7:0]      size_q, size_d;
    logic [1:0]      n_store;
    logic [7:0]      b0, b1;
    logic [6:0]      wr_idx, wr_idx_nxt;
    logic            accepting, timer_active, timer_expired;

    assign accepting    = (state_q == ST_IDLE) || (state_q == ST_ACCUM) || (state_q == ST_PEND_BE);
    assign timer_active = (state_q == ST_ACCUM) || (state_q == ST_PEND_BE);
    assign wr_idx       = size_q[6:0];
    assign wr_idx_nxt   = wr_idx + 7'd1;

    cmd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (reset),
        .enable_i  (timer_active),
        .clear_i   (accumulate),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            size_q  <= size_d;
        end
    end

    // Byte decode: how many payload bytes to commit and where the FSM goes if they fit.
    always_comb begin
        n_store = 2'd0;
        b0      = input_data;
        b1      = input_data;
        st_ok   = state_q;
        if (accepting && accumulate) begin
            if (ble_side && input_data == BLE_TERM) begin
                st_ok = ST_DONE;
            end else if (state_q == ST_PEND_BE) begin
                if (!ble_side && input_data == UART_TERM1) begin
                    st_ok = ST_DONE;
                end else if (!ble_side && input_data == UART_TERM0) begin
                    n_store = 2'd1;
                    b0      = UART_TERM0;
                    st_ok   = ST_PEND_BE;
                end else begin
                    n_store = 2'd2;
                    b0      = UART_TERM0;
                    st_ok   = ST_ACCUM;
                end
            end else if (!ble_side && input_data == UART_TERM0) begin
                st_ok = ST_PEND_BE;
            end else begin
                n_store = 2'd1;
                st_ok   = ST_ACCUM;
            end
        end
    end

    // Overflow rejects the whole store so the buffer and size keep their last legal values.
    always_comb begin
        state_d = st_ok;
        data_d  = data_q;
        size_d  = size_q;
        if (n_store == 2'd1) begin
            if (size_q < 8'(MAX_BYTES)) begin
                data_d[{wr_idx, 3'b000} +: 8] = b0;
                size_d                        = size_q + 8'd1;
            end else begin
                state_d = ST_ERROR;
            end
        end else if (n_store == 2'd2) begin
            if (size_q <= 8'(MAX_BYTES - 2)) begin
                data_d[{wr_idx, 3'b000} +: 8]     = b0;
                data_d[{wr_idx_nxt, 3'b000} +: 8] = b1;
                size_d                            = size_q + 8'd2;
            end else begin
                state_d = ST_ERROR;
            end
        end else if (timer_expired) begin
            state_d = ST_ERROR;
        end
    end

    always_comb begin
        output_data      = data_q;
        output_data_size = size_q;
        done             = (state_q == ST_DONE);
        error            = (state_q == ST_ERROR);
    end
endmodule

// File: tb/tb_uart_command_accumulator.sv
// tb/tb_uart_command_accumulator.sv - directed self-checking bench for uart_command_accumulator
module tb_uart_command_accumulator;
    localparam int TIMEOUT = 1026;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    input_data = 8'h00;
    logic          accumulate = 1'b0;
    logic          ble_side = 1'b0;
    logic [1023:0] output_data;
    logic [7:0]    output_data_size;
    logic          done;
    logic          error;

    int            checks = 0;
    int            failures = 0;
    logic [1023:0] exp_data;

    always #5 clk = ~clk;

    uart_command_accumulator #(.TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .input_data       (input_data),
        .accumulate       (accumulate),
        .ble_side         (ble_side),
        .output_data      (output_data),
        .output_data_size (output_data_size),
        .done             (done),
        .error            (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag);
        int w;
        w = 0;
        for (int i = 31; i >= 0; i--) begin
            if (output_data[32*i +: 32] !== exp_data[32*i +: 32]) w = i;
        end
        checks++;
        assert (output_data === exp_data) else begin
            failures++;
            $error("FAIL %s word=%0d observed=0x%08h expected=0x%08h", tag, w,
                   output_data[32*w +: 32], exp_data[32*w +: 32]);
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1 with the byte consumed.
    task automatic send(input logic [7:0] b);
        input_data = b;
        accumulate = 1'b1;
        @(posedge clk);
        #1;
        accumulate = 1'b0;
        input_data = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        chk("reset_size", 32'(output_data_size), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk_data("reset_data");

        idle(TIMEOUT + 50);
        chk("idle_no_timeout", 32'(error), 32'd0);

        // UART normal command
        ble_side = 1'b0;
        for (int k = 0; k < 10; k++) send(8'h27);
        send(8'hBE);
        chk("uart_pend_done", 32'(done), 32'd0);
        chk("uart_pend_size", 32'(output_data_size), 32'd10);
        send(8'hEF);
        for (int k = 0; k < 10; k++) exp_data[8*k +: 8] = 8'h27;
        chk("uart_done", 32'(done), 32'd1);
        chk("uart_error", 32'(error), 32'd0);
        chk("uart_size", 32'(output_data_size), 32'd10);
        chk_data("uart_data");
        send(8'h55);
        chk("uart_absorb_size", 32'(output_data_size), 32'd10);
        chk("uart_absorb_done", 32'(done), 32'd1);
        chk_data("uart_absorb_data");

        // Inter-byte timeout
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send(8'(k + 1));
            exp_data[8*k +: 8] = 8'(k + 1);
        end
        idle(TIMEOUT - 1);
        chk("tmo_not_yet", 32'(error), 32'd0);
        idle(1);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_done", 32'(done), 32'd0);
        chk("tmo_size", 32'(output_data_size), 32'd10);
        chk_data("tmo_data");
        do_reset();
        chk("tmo_rst_error", 32'(error), 32'd0);
        chk("tmo_rst_size", 32'(output_data_size), 32'd0);
        chk_data("tmo_rst_data");

        // Max fill then terminator
        for (int k = 0; k < 128; k++) begin
            send(8'(k + 1));
            exp_data[8*k +: 8] = 8'(k + 1);
        end
        send(8'hBE);
        send(8'hEF);
        chk("max_done", 32'(done), 32'd1);
        chk("max_error", 32'(error), 32'd0);
        chk("max_size", 32'(output_data_size), 32'd128);
        chk("max_first", 32'(output_data[7:0]), 32'h01);
        chk("max_last", 32'(output_data[1023:1016]), 32'h80);
        chk_data("max_data");

        // Overflow on the 129th byte
        do_reset();
        for (int k = 0; k < 128; k++) begin
            send(8'(k + 1));
            exp_data[8*k +: 8] = 8'(k + 1);
        end
        chk("ovf_pre_error", 32'(error), 32'd0);
        send(8'h81);
        chk("ovf_error", 32'(error), 32'd1);
        chk("ovf_done", 32'(done), 32'd0);
        chk("ovf_size", 32'(output_data_size), 32'd128);
        chk_data("ovf_data");
        send(8'h0D);
        send(8'h42);
        chk("ovf_absorb_size", 32'(output_data_size), 32'd128);
        chk("ovf_absorb_error", 32'(error), 32'd1);
        chk("ovf_absorb_done", 32'(done), 32'd0);

        // BLE: UART terminator bytes are payload, 0x0D ends the command
        do_reset();
        ble_side = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send(8'h27);
            exp_data[8*k +: 8] = 8'h27;
        end
        send(8'hBE);
        send(8'hEF);
        exp_data[8*10 +: 8] = 8'hBE;
        exp_data[8*11 +: 8] = 8'hEF;
        chk("ble_not_done", 32'(done), 32'd0);
        chk("ble_size12", 32'(output_data_size), 32'd12);
        chk_data("ble_data");
        send(8'h0D);
        chk("ble_done", 32'(done), 32'd1);
        chk("ble_error", 32'(error), 32'd0);
        chk("ble_final_size", 32'(output_data_size), 32'd12);
        chk_data("ble_final_data");
        ble_side = 1'b0;

        // UART false terminators
        do_reset();
        send(8'h11);
        send(8'hBE);
        send(8'h22);
        chk("false_two_store", 32'(output_data_size), 32'd3);
        send(8'hBE);
        send(8'hBE);
        chk("false_be_be_size", 32'(output_data_size), 32'd4);
        chk("false_be_be_done", 32'(done), 32'd0);
        send(8'hEF);
        exp_data[7:0]   = 8'h11;
        exp_data[15:8]  = 8'hBE;
        exp_data[23:16] = 8'h22;
        exp_data[31:24] = 8'hBE;
        chk("false_done", 32'(done), 32'd1);
        chk("false_size", 32'(output_data_size), 32'd4);
        chk_data("false_data");

        // Asynchronous reset mid-command
        do_reset();
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        chk("mid_size_pre", 32'(output_data_size), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_async_size", 32'(output_data_size), 32'd0);
        chk("mid_async_data", 32'(output_data[31:0]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_command_accumulator.md
Name: uart_command_accumulator

Overview:
- Collects a byte stream from a UART or BLE receiver into a 1024-bit command buffer, one byte per `accumulate` strobe.
- Flags `done` when the command terminator arrives.
- Flags `error` on buffer overflow or inter-byte timeout.
- Sits between the byte receiver and the command decoder.

Parameters:
- TIMEOUT, 1026, clock cycles allowed between consecutive accepted bytes once a command has started; a counter of at least clog2(TIMEOUT+1) bits.
- MAX_BYTES, 128, payload capacity in bytes (1024/8); fixed.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- input_data  input  8  received byte, valid while accumulate=1
- accumulate  input  1  byte strobe, sampled on rising clk; each cycle it is high accepts one byte
- ble_side  input  1  terminator select: 0 = UART (0xBE 0xEF), 1 = BLE (0x0D); sampled per byte
- output_data  output  1024  payload; byte k at bits [8k+7:8k], first byte at [7:0]
- output_data_size  output  8  payload byte count, 0..128
- done  output  1  command complete, sticky
- error  output  1  overflow or timeout, sticky

Behaviour:
- Reset (reset=0, asynchronous):
  - output_data=0, output_data_size=0, done=0, error=0.
  - Timeout counter cleared; state=IDLE.
- States: IDLE, ACCUM, PEND_BE (UART side only), DONE, ERROR.
- Byte acceptance: only in IDLE, ACCUM or PEND_BE, on a rising edge with accumulate=1. Terminator bytes are never stored or counted.
- BLE side (ble_side=1):
  - 0x0D -> done=1, state DONE, next cycle.
  - Any other byte (0xBE and 0xEF included) is stored at index output_data_size, size+1.
- UART side (ble_side=0):
  - In IDLE/ACCUM:
    - 0xBE -> PEND_BE; not stored.
    - Other byte -> stored, size+1.
  - In PEND_BE:
    - 0xEF -> done=1, DONE; the 0xBE is discarded.
    - 0xBE -> commit the held 0xBE as data, stay PEND_BE.
    - Other byte -> commit 0xBE then the new byte (size+2 in one cycle), return to ACCUM.
- Overflow: any store that would take size above 128 -> error=1, ERROR.
  - No partial write of the offending byte.
  - Size stays at its last legal value.
  - Example: the 129th payload byte errors. 128 payload bytes + 0xBE 0xEF is legal and gives done.
- Timeout:
  - The counter is active in ACCUM and PEND_BE and is cleared on every accepted byte.
  - When TIMEOUT consecutive cycles pass without accumulate -> error=1, ERROR.
  - No timeout in IDLE.
- Latency: payload and size update on the same clock edge that samples the byte. done/error assert on that edge and are visible the following cycle.
- DONE and ERROR are absorbing. accumulate is ignored and output_data/output_data_size are held until reset.
- done and error are never both 1.
- Simultaneous terminator and overflow cannot occur, since terminators are not stored.
- Reset mid-command discards everything immediately.

Decomposition:
- Shared package `uart_cmd_pkg`:
  - constants UART_TERM0=8'hBE, UART_TERM1=8'hEF, BLE_TERM=8'h0D, MAX_BYTES=128.
  - state enum.
- Optional single sub-module `cmd_timeout_counter`: load/clear/expire, parameterised by TIMEOUT. Everything else stays in one module.

Test Plan:
- UART normal: ble_side=0, ten 0x27, then 0xBE, 0xEF -> done=1, error=0, size=10, output_data[79:0]=all 0x27, upper bits 0.
- Timeout: bytes 0x01..0x0A, then idle >1026 cycles -> error=1 exactly TIMEOUT cycles after the last byte, size=10, done=0; reset clears all outputs.
- Max fill: 128 bytes 0x01..0x80, then 0xBE 0xEF -> done=1, size=128, output_data[7:0]=0x01, output_data[1023:1016]=0x80.
- Overflow: 129 bytes 0x01..0x81 -> error=1 on the 129th, size=128, byte 0x81 not stored; further strobes ignored.
- BLE: ble_side=1, ten 0x27, then 0xBE, 0xEF -> done stays 0, size=12 with bytes 10/11 = 0xBE/0xEF; then 0x0D -> done=1, size=12.
- UART false terminator: 0x11, 0xBE, 0x22, 0xBE, 0xBE, 0xEF -> done=1, size=4, data 0x11,0xBE,0x22,0xBE.
